// File: rtl/csr_update_pkg.sv
// Shared types and helpers for the CSR update queue.
// Entry layout, widths and lane addressing.
package csr_update_pkg;

  localparam int CSR_IDW = 12;
  localparam int CSR_VW  = 64;

  localparam logic KIND_CSR  = 1'b0;
  localparam logic KIND_PRIV = 1'b1;

  typedef struct packed {
    logic               kind;
    logic [CSR_IDW-1:0] id;
    logic [CSR_VW-1:0]  val;
    logic [31:0]        hartid;
  } entry_t;

  function automatic int lane_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/csr_update_fifo.sv
// Multi-write, single-read FIFO with occupancy count.
// Empty head shows the last popped entry (0 after reset).
module csr_update_fifo #(
  parameter  int DEPTH = 16,
  parameter  int NW    = 9,
  parameter  int W     = 109,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NW-1:0]        wr_en,
  input  logic [NW-1:0][W-1:0] wr_data,
  input  logic                 rd_en,
  output logic [W-1:0]         rd_data,
  output logic [CW-1:0]        count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  last_q;

  logic [NW-1:0][AW-1:0] off;
  logic [CW-1:0]         nwr;
  logic                  pop;

  // Active write ports are packed densely from wptr in port order.
  always_comb begin
    nwr = '0;
    for (int i = 0; i < NW; i++) begin
      off[i] = wptr_q + nwr[AW-1:0];
      nwr    = nwr + CW'(wr_en[i]);
    end
  end

  assign pop     = rd_en & (cnt_q != '0);
  assign count   = cnt_q;
  assign rd_data = (cnt_q != '0) ? mem_q[rptr_q] : last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wptr_q <= wptr_q + nwr[AW-1:0];
      cnt_q  <= cnt_q + nwr - CW'(pop);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        last_q <= mem_q[rptr_q];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin
        if (wr_en[i]) mem_q[off[i]] <= wr_data[i];
      end
    end
  end

endmodule

// File: rtl/csr_update_queue.sv
// Reports changed CSR channels and privilege level through a FIFO.
// Lanes 0..NCH-1 are CSR channels; lane NCH is the privilege level.
module csr_update_queue
  import csr_update_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DEPTH = 16,
  parameter int IDW   = CSR_IDW,
  parameter int VW    = CSR_VW
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         en,
  input  logic [NCH*(IDW+VW)-1:0]      csr_in,
  input  logic [1:0]                   priv,
  input  logic [31:0]                  hartid,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_kind,
  output logic [IDW-1:0]               out_id,
  output logic [VW-1:0]                out_val,
  output logic [31:0]                  out_hartid,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         overflow,
  output logic [15:0]                  defer_cnt
);

  localparam int L   = NCH + 1;
  localparam int CHW = IDW + VW;
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int EW  = $bits(entry_t);

  logic [L-1:0][IDW-1:0] ln_id, sh_id_q;
  logic [L-1:0][VW-1:0]  ln_val, sh_val_q;
  logic [L-1:0]          seen_q, chg, gnt;
  logic [L-1:0][EW-1:0]  wr_data;
  logic [EW-1:0]         rd_data;
  entry_t                head;
  logic [CW-1:0]         free, used;
  logic                  pop, deferred;
  logic                  overflow_q;
  logic [15:0]           defer_q;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      {ln_id[k], ln_val[k]} = csr_in[lane_off(k, CHW) +: CHW];
    end
    ln_id[NCH]  = '0;
    ln_val[NCH] = VW'(priv);
  end

  always_comb begin
    for (int k = 0; k < L; k++) begin
      chg[k] = en & (!seen_q[k] | (ln_id[k] != sh_id_q[k])
                                | (ln_val[k] != sh_val_q[k]));
    end
  end

  assign pop  = out_valid & out_ready;
  assign free = CW'(DEPTH) - count + CW'(pop);

  // Lowest lanes win while slots remain; the rest retry next cycle.
  always_comb begin
    used = '0;
    gnt  = '0;
    for (int k = 0; k < L; k++) begin
      if (chg[k] && (used < free)) begin
        gnt[k] = 1'b1;
        used   = used + CW'(1);
      end
    end
  end

  assign deferred = |(chg & ~gnt);

  always_comb begin
    for (int k = 0; k < L; k++) begin
      wr_data[k] = entry_t'{
        kind:   (k == NCH) ? KIND_PRIV : KIND_CSR,
        id:     ln_id[k],
        val:    ln_val[k],
        hartid: hartid
      };
    end
  end

  csr_update_fifo #(
    .DEPTH (DEPTH),
    .NW    (L),
    .W     (EW)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (gnt),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (rd_data),
    .count   (count)
  );

  assign head       = entry_t'(rd_data);
  assign out_valid  = (count != '0);
  assign out_kind   = head.kind;
  assign out_id     = head.id;
  assign out_val    = head.val;
  assign out_hartid = head.hartid;
  assign overflow   = overflow_q;
  assign defer_cnt  = defer_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      seen_q     <= '0;
      sh_id_q    <= '0;
      sh_val_q   <= '0;
      overflow_q <= 1'b0;
      defer_q    <= '0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (gnt[k]) begin
          seen_q[k]   <= 1'b1;
          sh_id_q[k]  <= ln_id[k];
          sh_val_q[k] <= ln_val[k];
        end
      end
      if (deferred) begin
        overflow_q <= 1'b1;
        if (defer_q != 16'hFFFF) defer_q <= defer_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_csr_update_queue.sv
// Directed bench for csr_update_queue (NCH=8, DEPTH=16).
// Expected entries are built from the bench's own lane values.
module tb_csr_update_queue;

  localparam int NCH = 8;
  localparam int L   = NCH + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [NCH*76-1:0] csr_in = '0;
  logic [1:0]        priv = '0;
  logic [31:0]       hartid = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic              out_kind;
  logic [11:0]       out_id;
  logic [63:0]       out_val;
  logic [31:0]       out_hartid;
  logic [4:0]        count;
  logic              overflow;
  logic [15:0]       defer_cnt;

  int nvec = 0;
  int nerr = 0;

  logic [63:0]  lval [L];
  logic [108:0] exp_q [$];
  logic [108:0] e;
  logic [108:0] got;

  assign got = {out_kind, out_id, out_val, out_hartid};

  csr_update_queue #(.NCH(NCH), .DEPTH(16), .IDW(12), .VW(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .en         (en),
    .csr_in     (csr_in),
    .priv       (priv),
    .hartid     (hartid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_id     (out_id),
    .out_val    (out_val),
    .out_hartid (out_hartid),
    .count      (count),
    .overflow   (overflow),
    .defer_cnt  (defer_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [63:0] v);
    lval[k] = v;
    csr_in[k*76 +: 76] = {12'(12'h300 + k), v};
  endtask

  function automatic logic [108:0] lane_exp(input int k);
    if (k == NCH) return {1'b1, 12'h000, 62'h0, priv, hartid};
    return {1'b0, 12'(12'h300 + k), lval[k], hartid};
  endfunction

  task automatic test_reset;
    reset = 1'b1; en = 1'b0;
    tick; tick;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b exp 0", out_valid); end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL rst_count got %0d exp 0", count); end
    nvec++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b exp 0", overflow); end
    nvec++; if (defer_cnt !== 16'd0) begin nerr++; $display("FAIL rst_defer got %0d exp 0", defer_cnt); end
    nvec++; if (got !== '0) begin nerr++; $display("FAIL rst_head got %h exp 0", got); end
    reset = 1'b0;
  endtask

  task automatic test_all_lanes;
    for (int k = 0; k < NCH; k++) set_ch(k, 64'h1000 + 64'(k));
    priv = 2'd3; hartid = 32'hA5; out_ready = 1'b0; en = 1'b1;
    for (int k = 0; k < L; k++) exp_q.push_back(lane_exp(k));
    tick;
    nvec++; if (count !== 5'd9) begin nerr++; $display("FAIL all_count got %0d exp 9", count); end
    out_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      e = exp_q.pop_front();
      nvec++; if (out_valid !== 1'b1 || got !== e) begin nerr++; $display("FAIL all_entry%0d got %b/%h exp 1/%h", i, out_valid, got, e); end
      tick;
    end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL all_drained got %0d exp 0", count); end
  endtask

  task automatic test_steady;
    for (int i = 0; i < 20; i++) begin
      tick;
      nvec++; if (out_valid !== 1'b0 || count !== 5'd0) begin nerr++; $display("FAIL steady%0d got %b/%0d exp 0/0", i, out_valid, count); end
    end
    nvec++; if (out_kind !== 1'b1 || out_val !== 64'd3) begin nerr++; $display("FAIL steady_hold got %b/%h exp 1/3", out_kind, out_val); end
  endtask

  task automatic test_hold;
    set_ch(2, 64'h10);
    tick; tick;
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL hold_pre got %0d exp 0", count); end
    out_ready = 1'b0;
    set_ch(2, 64'h20);
    e = lane_exp(2);
    tick;
    for (int i = 0; i < 5; i++) begin
      nvec++; if (out_valid !== 1'b1 || got !== e || count !== 5'd1) begin nerr++; $display("FAIL hold%0d got %b/%h/%0d exp 1/%h/1", i, out_valid, got, count, e); end
      tick;
    end
    out_ready = 1'b1;
    tick;
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL hold_pop got %0d exp 0", count); end
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 64'hA000 + 64'(k));
    priv = 2'd1;
    for (int k = 0; k < L; k++) exp_q.push_back(lane_exp(k));
    tick;
    nvec++; if (count !== 5'd9) begin nerr++; $display("FAIL ovf_a got %0d exp 9", count); end
    for (int k = 0; k < NCH; k++) set_ch(k, 64'hB000 + 64'(k));
    priv = 2'd2;
    for (int k = 0; k < L; k++) exp_q.push_back(lane_exp(k));
    tick;
    nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL ovf_cnt got %0d exp 16", count); end
    nvec++; if (overflow !== 1'b1) begin nerr++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    nvec++; if (defer_cnt !== 16'd1) begin nerr++; $display("FAIL ovf_defer got %0d exp 1", defer_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front();
      nvec++; if (out_valid !== 1'b1 || got !== e) begin nerr++; $display("FAIL ovf_entry%0d got %b/%h exp 1/%h", i, out_valid, got, e); end
      tick;
    end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL ovf_drained got %0d exp 0", count); end
    nvec++; if (defer_cnt !== 16'd2) begin nerr++; $display("FAIL ovf_defer_end got %0d exp 2", defer_cnt); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) set_ch(k, 64'hE000 + 64'(k));
    hartid = 32'd7;
    tick;
    nvec++; if (count !== 5'd5) begin nerr++; $display("FAIL mid_fill got %0d exp 5", count); end
    reset = 1'b1;
    tick;
    nvec++; if (out_valid !== 1'b0 || count !== 5'd0) begin nerr++; $display("FAIL mid_rst got %b/%0d exp 0/0", out_valid, count); end
    nvec++; if (overflow !== 1'b0 || defer_cnt !== 16'd0) begin nerr++; $display("FAIL mid_flags got %b/%0d exp 0/0", overflow, defer_cnt); end
    nvec++; if (got !== '0) begin nerr++; $display("FAIL mid_head got %h exp 0", got); end
    reset = 1'b0;
    for (int k = 0; k < L; k++) exp_q.push_back(lane_exp(k));
    tick;
    nvec++; if (count !== 5'd9) begin nerr++; $display("FAIL mid_rereport got %0d exp 9", count); end
    hartid = 32'd9;
    out_ready = 1'b1;
    for (int i = 0; i < L; i++) begin
      e = exp_q.pop_front();
      nvec++; if (out_valid !== 1'b1 || got !== e) begin nerr++; $display("FAIL mid_entry%0d got %b/%h exp 1/%h", i, out_valid, got, e); end
      tick;
    end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL mid_drained got %0d exp 0", count); end
  endtask

  task automatic test_full_pop_push;
    out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) set_ch(k, 64'hF000 + 64'(k));
    priv = 2'd3;
    for (int k = 0; k < L; k++) exp_q.push_back(lane_exp(k));
    tick;
    for (int k = 0; k < 7; k++) begin
      set_ch(k, 64'hC000 + 64'(k));
      exp_q.push_back(lane_exp(k));
    end
    tick;
    nvec++; if (count !== 5'd16 || overflow !== 1'b0) begin nerr++; $display("FAIL full_fill got %0d/%b exp 16/0", count, overflow); end
    e = exp_q.pop_front();
    nvec++; if (got !== e) begin nerr++; $display("FAIL full_head got %h exp %h", got, e); end
    out_ready = 1'b1;
    set_ch(0, 64'hD000);
    exp_q.push_back(lane_exp(0));
    tick;
    nvec++; if (count !== 5'd16) begin nerr++; $display("FAIL pp_count got %0d exp 16", count); end
    nvec++; if (overflow !== 1'b0 || defer_cnt !== 16'd0) begin nerr++; $display("FAIL pp_flags got %b/%0d exp 0/0", overflow, defer_cnt); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front();
      nvec++; if (out_valid !== 1'b1 || got !== e) begin nerr++; $display("FAIL pp_entry%0d got %b/%h exp 1/%h", i, out_valid, got, e); end
      tick;
    end
    nvec++; if (count !== 5'd0) begin nerr++; $display("FAIL pp_drained got %0d exp 0", count); end
  endtask

  initial begin
    for (int k = 0; k < L; k++) lval[k] = '0;
    test_reset;
    test_all_lanes;
    test_steady;
    test_hold;
    test_overflow;
    test_reset_mid;
    test_full_pop_push;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/csr_update_queue.md
Name: csr_update_queue

Overview:
- Parametrised successor to the per-cycle CSR/privilege difftest reporter.
- Monitors NCH packed CSR channels ({12-bit csr id, 64-bit value}) plus the privilege level.
- Enqueues only changed values into a DEPTH-entry FIFO and drains them one per cycle over a valid/ready port to the DPI-calling sink.
- Sits between the core CSR file and the difftest interface; removes the fixed 9-calls-per-cycle cost.

Parameters:
- NCH, 8: number of CSR channels, 1..16.
- DEPTH, 16: FIFO entries, power of two, at least NCH+1.
- IDW, 12: CSR id width.
- VW, 64: CSR value width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- en  in  1  sampling enable; when 0, nothing is compared or enqueued
- csr_in  in  NCH*(IDW+VW)  channel k at bits [k*76+75 : k*76]; {id, value}
- priv  in  2  current privilege level
- hartid  in  32  hart index, passed through registered with each entry
- out_valid  out  1  head entry valid
- out_ready  in  1  sink accepts head
- out_kind  out  1  0 = CSR entry, 1 = privilege entry
- out_id  out  IDW  CSR id (0 for privilege entries)
- out_val  out  VW  value (privilege zero-extended)
- out_hartid  out  32  hartid captured at enqueue
- count  out  $clog2(DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky; a change was deferred for lack of space
- defer_cnt  out  16  saturating count of lane-deferral events

Behaviour:
- Lanes: L = NCH+1. Lane k<NCH is CSR channel k; lane NCH is priv.
- Shadow state per lane: last-reported {id, value} and a seen bit. Reset clears every seen bit.
- Lane change: en=1 and (seen=0, or id differs from shadow, or value differs from shadow).
- Enqueue rules:
  - Changed lanes are granted in ascending lane order while free = DEPTH - count + pop, where pop = out_valid & out_ready in the same cycle.
  - Multiple writes per cycle are allowed, up to min(L, free).
  - Granted lane: entry written; shadow and seen updated.
  - Ungranted changed lane: shadow untouched, so it re-compares next cycle. Only the latest value is reported; intermediate values may be lost. overflow is set, and defer_cnt increments by 1 per cycle with at least one deferral, saturating at 0xFFFF.
- Latency: change sampled at edge t is visible at out_valid no earlier than the cycle after t. No combinational path from csr_in to out_*.
- Output: out_* driven from the FIFO head register. out_* must remain stable while out_valid=1 and out_ready=0. Pop occurs when valid & ready.
- Simultaneous pop and push at full: pop frees one slot, usable in the same cycle.
- Empty: out_valid=0; out_kind, out_id, out_val and out_hartid hold their last values (0 after reset).
- Pointers: log2(DEPTH)-bit read/write pointers with wrap-around; count is tracked separately, so full/empty are unambiguous.
- Reset, including mid-drain:
  - All FIFO contents discarded.
  - count=0, out_valid=0, out_* = 0, overflow=0, defer_cnt=0, seen=0.
  - First en cycle after reset reports every lane.
- Entry ordering within a cycle is lane order; across cycles, FIFO order.

Decomposition:
- Package csr_update_pkg:
  - entry typedef {kind, id, val, hartid}
  - IDW/VW constants
  - lane-offset function
  - KIND_CSR / KIND_PRIV constants
- Sub-module csr_update_fifo: multi-write (up to L ports), single-read FIFO with count output.
- Change detection and grant logic live in the top level.

Test Plan:
1. Reset, then en=1 with NCH=8 distinct channels and priv=3 -> 9 entries drained in lane order; last entry has kind=1, val=3; count peaks at 9.
2. Steady inputs for 20 cycles after drain -> out_valid stays 0, count=0.
3. Channel 2 value 0x10 -> 0x20 with out_ready held low for 5 cycles -> single entry (id of ch2, val 0x20) held stable for 5 cycles, then popped.
4. DEPTH=16, out_ready=0, all 9 lanes change on two consecutive cycles -> second cycle grants lanes 0..6 and defers 7..8. overflow=1, defer_cnt=1. After one pop, the deferred lanes carry their latest values.
5. Fill FIFO, then pop and a 1-lane change in the same cycle -> count unchanged, entry accepted, no overflow.
6. Assert reset with 5 entries queued -> next cycle out_valid=0, count=0. First cycle with en=1 re-reports all 9 lanes.
